// File: rtl/gpio_ctrl_if.sv
// Single-cycle register bus between the IO module (master) and gpio_ctrl (slave).
// Strobes are one cycle wide; read data is registered in the slave.
interface gpio_ctrl_if #(
    parameter int WIDTH = 32
);
    logic [2:0]       bus_addr;
    logic             bus_we;
    logic             bus_re;
    logic [WIDTH-1:0] bus_wdata;
    logic [WIDTH-1:0] bus_rdata;

    modport master (
        output bus_addr,
        output bus_we,
        output bus_re,
        output bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr,
        input  bus_we,
        input  bus_re,
        input  bus_wdata,
        output bus_rdata
    );
endinterface

// File: rtl/gpio_ctrl.sv
// Clocked GPIO controller: direction/output/input registers, input synchroniser,
// edge-triggered sticky W1C interrupts. Optional per-pin debounce under GPIO_DEBOUNCE_EN.
module gpio_ctrl #(
    parameter int WIDTH           = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    gpio_ctrl_if.slave       bus,
    input  logic [WIDTH-1:0] GPIO_IN,
    output logic [WIDTH-1:0] GPIO_OUT,
    output logic [WIDTH-1:0] GPIO_DIR,
    output logic             irq
);

    localparam logic [2:0] ADDR_CR   = 3'd0;
    localparam logic [2:0] ADDR_OR   = 3'd1;
    localparam logic [2:0] ADDR_IR   = 3'd2;
    localparam logic [2:0] ADDR_IER  = 3'd3;
    localparam logic [2:0] ADDR_IEF  = 3'd4;
    localparam logic [2:0] ADDR_ISR  = 3'd5;
    localparam logic [2:0] ADDR_OSET = 3'd6;
    localparam logic [2:0] ADDR_OCLR = 3'd7;

    logic [WIDTH-1:0] cr_reg,    cr_next;
    logic [WIDTH-1:0] or_reg,    or_next;
    logic [WIDTH-1:0] ier_reg,   ier_next;
    logic [WIDTH-1:0] ief_reg,   ief_next;
    logic [WIDTH-1:0] isr_reg,   isr_next;
    logic [WIDTH-1:0] rdata_reg, rdata_next;
    logic [WIDTH-1:0] prev_reg;
    logic             irq_reg;

    logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] acc_in;
    logic [WIDTH-1:0] ir_val;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] w1c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
        end else begin
            sync_reg[0] <= GPIO_IN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    assign sync_in = sync_reg[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    genvar gi;
    for (gi = 0; gi < WIDTH; gi++) begin : g_debounce
        logic [CNT_W-1:0] cnt_reg;
        logic [CNT_W-1:0] cnt_inc;
        logic             acc_reg;

        assign cnt_inc = cnt_reg + 1'b1;

        // A pin that flips back to the accepted value before the count completes restarts from zero.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_reg <= '0;
                acc_reg <= 1'b0;
            end else if (sync_in[gi] == acc_reg) begin
                cnt_reg <= '0;
            end else if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
                cnt_reg <= '0;
                acc_reg <= sync_in[gi];
            end else begin
                cnt_reg <= cnt_inc;
            end
        end

        assign acc_in[gi] = acc_reg;
    end
`else
    logic unused_debounce_cfg;
    assign unused_debounce_cfg = (DEBOUNCE_CYCLES > 0);
    assign acc_in              = sync_in;
`endif

    // Output pins are masked so they neither read back nor raise edges; prev tracks regardless of CR.
    assign ir_val = acc_in & ~cr_reg;
    assign rise   = acc_in & ~prev_reg & ~cr_reg;
    assign fall   = ~acc_in & prev_reg & ~cr_reg;

    always_comb begin
        cr_next  = cr_reg;
        or_next  = or_reg;
        ier_next = ier_reg;
        ief_next = ief_reg;
        w1c      = '0;
        if (bus.bus_we) begin
            case (bus.bus_addr)
                ADDR_CR:   cr_next  = bus.bus_wdata;
                ADDR_OR:   or_next  = bus.bus_wdata;
                ADDR_IER:  ier_next = bus.bus_wdata;
                ADDR_IEF:  ief_next = bus.bus_wdata;
                ADDR_ISR:  w1c      = bus.bus_wdata;
                ADDR_OSET: or_next  = or_reg | bus.bus_wdata;
                ADDR_OCLR: or_next  = or_reg & ~bus.bus_wdata;
                default:   ;
            endcase
        end
    end

    // New events win over a simultaneous clear so none are lost.
    assign isr_next = (isr_reg & ~w1c) | (rise & ier_reg) | (fall & ief_reg);

    always_comb begin
        rdata_next = rdata_reg;
        if (bus.bus_re) begin
            case (bus.bus_addr)
                ADDR_CR:  rdata_next = cr_reg;
                ADDR_OR:  rdata_next = or_reg;
                ADDR_IR:  rdata_next = ir_val;
                ADDR_IER: rdata_next = ier_reg;
                ADDR_IEF: rdata_next = ief_reg;
                ADDR_ISR: rdata_next = isr_reg;
                default:  rdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cr_reg    <= '0;
            or_reg    <= '0;
            ier_reg   <= '0;
            ief_reg   <= '0;
            isr_reg   <= '0;
            rdata_reg <= '0;
            prev_reg  <= '0;
            irq_reg   <= 1'b0;
        end else begin
            cr_reg    <= cr_next;
            or_reg    <= or_next;
            ier_reg   <= ier_next;
            ief_reg   <= ief_next;
            isr_reg   <= isr_next;
            rdata_reg <= rdata_next;
            prev_reg  <= acc_in;
            irq_reg   <= |isr_reg;
        end
    end

    assign GPIO_OUT      = cr_reg & or_reg;
    assign GPIO_DIR      = cr_reg;
    assign irq           = irq_reg;
    assign bus.bus_rdata = rdata_reg;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: register table, then hand sequences for
// input latency, edge interrupts, W1C collision, read/write overlap and async reset.
module tb_gpio_ctrl;

    localparam int W      = 32;
    localparam int SYNC   = 2;
    localparam int DB     = 4;
`ifdef GPIO_DEBOUNCE_EN
    localparam int IN_LAT = SYNC + DB;
`else
    localparam int IN_LAT = SYNC;
`endif

    logic         clk;
    logic         rst;
    logic [W-1:0] gpio_in;
    logic [W-1:0] gpio_out;
    logic [W-1:0] gpio_dir;
    logic         irq;

    gpio_ctrl_if #(.WIDTH(W)) bus_if ();

    gpio_ctrl #(
        .WIDTH           (W),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if.slave),
        .GPIO_IN  (gpio_in),
        .GPIO_OUT (gpio_out),
        .GPIO_DIR (gpio_dir),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q [$];
    string        name_q [$];

    typedef struct {
        bit           wr;
        logic [2:0]   addr;
        logic [W-1:0] data;
        logic [W-1:0] exp_rd;
        logic [W-1:0] exp_out;
        logic [W-1:0] exp_dir;
        string        name;
    } vec_t;

    vec_t vecs [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [W-1:0] data);
        bus_if.bus_addr  = addr;
        bus_if.bus_wdata = data;
        bus_if.bus_we    = 1'b1;
        tick();
        bus_if.bus_we    = 1'b0;
        $display("wr   addr=%0d data=0x%08h", addr, data);
    endtask

    // Expected data is queued with the strobe and compared when rdata is produced.
    task automatic do_read(input logic [2:0] addr, input logic [W-1:0] exp, input string name);
        logic [W-1:0] e;
        string        n;
        exp_q.push_back(exp);
        name_q.push_back(name);
        bus_if.bus_addr = addr;
        bus_if.bus_re   = 1'b1;
        tick();
        bus_if.bus_re   = 1'b0;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, bus_if.bus_rdata, e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 3'd0, 32'h0000_00F0, 32'h0,          32'h0000_0000, 32'hF0, "wr_cr"};
        vecs[1]  = '{1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0,          32'h0000_00F0, 32'hF0, "wr_or"};
        vecs[2]  = '{1'b0, 3'd1, 32'h0,         32'hFFFF_FFFF, 32'h0000_00F0, 32'hF0, "rd_or"};
        vecs[3]  = '{1'b1, 3'd7, 32'h0000_0030, 32'h0,          32'h0000_00C0, 32'hF0, "wr_oclr"};
        vecs[4]  = '{1'b1, 3'd6, 32'h0000_0001, 32'h0,          32'h0000_00C0, 32'hF0, "wr_oset"};
        vecs[5]  = '{1'b0, 3'd1, 32'h0,         32'hFFFF_FFCF, 32'h0000_00C0, 32'hF0, "rd_or_after_setclr"};
        vecs[6]  = '{1'b0, 3'd6, 32'h0,         32'h0,          32'h0000_00C0, 32'hF0, "rd_oset_zero"};
        vecs[7]  = '{1'b0, 3'd7, 32'h0,         32'h0,          32'h0000_00C0, 32'hF0, "rd_oclr_zero"};
        vecs[8]  = '{1'b1, 3'd2, 32'h1234_5678, 32'h0,          32'h0000_00C0, 32'hF0, "wr_ir_ignored"};
        vecs[9]  = '{1'b0, 3'd2, 32'h0,         32'h0,          32'h0000_00C0, 32'hF0, "rd_ir"};
        vecs[10] = '{1'b1, 3'd3, 32'hA5A5_A5A5, 32'h0,          32'h0000_00C0, 32'hF0, "wr_ier"};
        vecs[11] = '{1'b0, 3'd3, 32'h0,         32'hA5A5_A5A5, 32'h0000_00C0, 32'hF0, "rd_ier"};
        vecs[12] = '{1'b1, 3'd4, 32'h0000_F0F0, 32'h0,          32'h0000_00C0, 32'hF0, "wr_ief"};
        vecs[13] = '{1'b0, 3'd4, 32'h0,         32'h0000_F0F0, 32'h0000_00C0, 32'hF0, "rd_ief"};
        vecs[14] = '{1'b0, 3'd0, 32'h0,         32'h0000_00F0, 32'h0000_00C0, 32'hF0, "rd_cr"};
        vecs[15] = '{1'b0, 3'd5, 32'h0,         32'h0,          32'h0000_00C0, 32'hF0, "rd_isr_idle"};

        rst              = 1'b0;
        gpio_in          = '0;
        bus_if.bus_addr  = '0;
        bus_if.bus_we    = 1'b0;
        bus_if.bus_re    = 1'b0;
        bus_if.bus_wdata = '0;
        ticks(2);
        rst = 1'b1;
        tick();

        check("reset_gpio_out", gpio_out, '0);
        check("reset_gpio_dir", gpio_dir, '0);
        check("reset_irq", {31'b0, irq}, '0);
        check("reset_rdata", bus_if.bus_rdata, '0);

        // Register table
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
            else            do_read(vecs[i].addr, vecs[i].exp_rd, vecs[i].name);
            check({vecs[i].name, "_out"}, gpio_out, vecs[i].exp_out);
            check({vecs[i].name, "_dir"}, gpio_dir, vecs[i].exp_dir);
        end

        // Input path: synchroniser latency and read-data hold
        bus_write(3'd3, '0);
        bus_write(3'd4, '0);
        bus_write(3'd0, 32'h0F);
        gpio_in = 32'hFF;
        ticks(IN_LAT - 1);
        do_read(3'd2, 32'h0, "ir_before_latency");
        do_read(3'd2, 32'hF0, "ir_after_latency");
        gpio_in = 32'h55;
        ticks(IN_LAT + 3);
        check("rdata_hold", bus_if.bus_rdata, 32'hF0);
        do_read(3'd2, 32'h50, "ir_0x55");
        do_read(3'd5, 32'h0, "isr_no_enables");

        // Edge interrupts
        bus_write(3'd0, '0);
        gpio_in = 32'h02;
        ticks(IN_LAT + 3);
        bus_write(3'd5, '1);
        bus_write(3'd3, 32'h1);
        bus_write(3'd4, 32'h2);
        do_read(3'd5, 32'h0, "isr_clean");
        gpio_in = 32'h03;
        ticks(IN_LAT + 1);
        check("irq_not_yet", {31'b0, irq}, 32'h0);
        tick();
        check("irq_rise", {31'b0, irq}, 32'h1);
        do_read(3'd5, 32'h1, "isr_rise_pin0");
        gpio_in = 32'h01;
        ticks(IN_LAT + 3);
        do_read(3'd5, 32'h3, "isr_fall_pin1");
        bus_write(3'd5, 32'h1);
        do_read(3'd5, 32'h2, "isr_w1c_bit0");
        check("irq_still_set", {31'b0, irq}, 32'h1);
        bus_write(3'd5, 32'h2);
        check("irq_lag_after_clear", {31'b0, irq}, 32'h1);
        tick();
        check("irq_cleared", {31'b0, irq}, 32'h0);

        // Collision: W1C lands on the edge where a new rise is detected
        gpio_in = 32'h00;
        ticks(IN_LAT + 3);
        gpio_in = 32'h01;
        ticks(IN_LAT + 3);
        do_read(3'd5, 32'h1, "isr_pre_collision");
        gpio_in = 32'h00;
        ticks(IN_LAT + 3);
        gpio_in = 32'h01;
        ticks(IN_LAT);
        bus_write(3'd5, 32'h1);
        do_read(3'd5, 32'h1, "isr_collision_kept");
        bus_write(3'd5, 32'h1);
        do_read(3'd5, 32'h0, "isr_plain_clear");

        // Write and read strobes together return the pre-write value
        exp_q.push_back(32'h0);
        name_q.push_back("we_re_prewrite");
        bus_if.bus_addr  = 3'd0;
        bus_if.bus_wdata = 32'h3C;
        bus_if.bus_we    = 1'b1;
        bus_if.bus_re    = 1'b1;
        tick();
        bus_if.bus_we    = 1'b0;
        bus_if.bus_re    = 1'b0;
        check(name_q.pop_front(), bus_if.bus_rdata, exp_q.pop_front());
        check("we_re_dir", gpio_dir, 32'h3C);
        do_read(3'd0, 32'h3C, "rd_cr_after_we_re");

        // Output-masked pins raise nothing, and turning them into inputs adds no edge
        bus_write(3'd3, 32'hFF);
        bus_write(3'd4, 32'hFF);
        bus_write(3'd5, '1);
        gpio_in = 32'h05;
        ticks(IN_LAT + 3);
        do_read(3'd5, 32'h0, "isr_masked_output_pin");
        bus_write(3'd0, '0);
        ticks(3);
        do_read(3'd5, 32'h0, "isr_no_spurious_dir_change");
        do_read(3'd2, 32'h05, "ir_all_inputs");

`ifdef GPIO_DEBOUNCE_EN
        // Short glitch rejected, steady level accepted
        gpio_in = 32'h0;
        ticks(IN_LAT + 3);
        bus_write(3'd5, '1);
        bus_write(3'd3, 32'h04);
        gpio_in = 32'h04;
        ticks(3);
        gpio_in = 32'h0;
        ticks(IN_LAT + 3);
        do_read(3'd5, 32'h0, "db_glitch_isr");
        do_read(3'd2, 32'h0, "db_glitch_ir");
        gpio_in = 32'h04;
        ticks(IN_LAT - 1);
        do_read(3'd2, 32'h0, "db_ir_before_accept");
        do_read(3'd2, 32'h04, "db_ir_accepted");
`endif

        // Asynchronous reset with all low ISR bits pending
        gpio_in = 32'h0;
        ticks(IN_LAT + 3);
        bus_write(3'd3, 32'hFF);
        bus_write(3'd5, '1);
        gpio_in = 32'hFF;
        ticks(IN_LAT + 3);
        do_read(3'd5, 32'hFF, "isr_ff");
        check("irq_before_reset", {31'b0, irq}, 32'h1);
        bus_write(3'd0, 32'hFF);
        bus_write(3'd1, 32'hFF);
        check("out_before_reset", gpio_out, 32'hFF);
        do_read(3'd5, 32'hFF, "isr_ff_sticky");
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_out", gpio_out, '0);
        check("async_rst_dir", gpio_dir, '0);
        check("async_rst_irq", {31'b0, irq}, '0);
        check("async_rst_rdata", bus_if.bus_rdata, '0);
        ticks(2);
        rst = 1'b1;
        tick();
        do_read(3'd0, 32'h0, "cr_after_reset");
        do_read(3'd5, 32'h0, "isr_after_reset");
        ticks(IN_LAT + 3);
        do_read(3'd5, 32'h0, "isr_after_reset_settle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
